// File: rtl/seg7_pkg.sv
// Shared constants and types for seven-segment readback logic.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 7;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001101;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0100011;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1001011;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // One recovered digit.
    typedef struct packed {
        logic [3:0] value;
        logic       blank;
        logic       err;
    } digit_t;

    // True when exactly one active-low enable is asserted.
    function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] an_n);
        logic [NUM_DIGITS-1:0] act;
        act = ~an_n;
        return (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to digit decoder.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output digit_t     dec_c
);

    // 7 and 14 share a pattern and decode as 7; 8, 15 and lamp test decode as 8.
    always_comb begin
        dec_c = '0;
        case (seg_n)
            SEG_0:     dec_c.value = 4'h0;
            SEG_1:     dec_c.value = 4'h1;
            SEG_2:     dec_c.value = 4'h2;
            SEG_3:     dec_c.value = 4'h3;
            SEG_4:     dec_c.value = 4'h4;
            SEG_5:     dec_c.value = 4'h5;
            SEG_6:     dec_c.value = 4'h6;
            SEG_7:     dec_c.value = 4'h7;
            SEG_8:     dec_c.value = 4'h8;
            SEG_9:     dec_c.value = 4'h9;
            SEG_A:     dec_c.value = 4'hA;
            SEG_B:     dec_c.value = 4'hB;
            SEG_C:     dec_c.value = 4'hC;
            SEG_D:     dec_c.value = 4'hD;
            SEG_BLANK: dec_c.blank = 1'b1;
            default:   dec_c.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Recovers 4-digit frames from a multiplexed common-anode segment bus.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] frame_data,
    output logic [3:0]  frame_blank,
    output logic [3:0]  frame_err,
    output logic        frame_valid,
    input  logic        frame_ack,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CNT);

    logic [3:0]            prev_an_q;
    logic [6:0]            prev_seg_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_c;
    logic                  commit_q;
    logic                  commit_c;
    logic                  sample_ok_c;
    logic                  same_c;

    digit_t                dec_c;
    digit_t                slot_q [NUM_DIGITS];
    digit_t                slot_c [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] mask_q;
    logic [NUM_DIGITS-1:0] mask_c;
    logic [NUM_DIGITS-1:0] sel_c;
    logic                  complete_c;

    logic [15:0]           pack_data_c;
    logic [3:0]            pack_blank_c;
    logic [3:0]            pack_err_c;
    logic                  load_c;
    logic                  overrun_set_c;

    // Stability counter next value and first-reach commit detection.
    always_comb begin
        sample_ok_c = onehot_low(an_n);
        same_c      = sample_ok_c && ({an_n, seg_n} == {prev_an_q, prev_seg_q});
        cnt_c       = '0;
        if (sample_ok_c) begin
            if (same_c) begin
                cnt_c = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_c = CNT_W'(1);
            end
        end
        commit_c = sample_ok_c && (cnt_c == CNT_TOP) && !(same_c && (cnt_q == CNT_TOP));
    end

    // Sample history, counter and commit pulse; the committed sample stays in prev_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_an_q  <= '0;
            prev_seg_q <= '0;
            cnt_q      <= '0;
            commit_q   <= 1'b0;
        end else begin
            prev_an_q  <= an_n;
            prev_seg_q <= seg_n;
            cnt_q      <= cnt_c;
            commit_q   <= commit_c;
        end
    end

    seg7_pattern_decode u_decode (
        .seg_n (prev_seg_q),
        .dec_c (dec_c)
    );

    // Slot update, capture mask and frame packing including the committing digit.
    always_comb begin
        sel_c      = commit_q ? ~prev_an_q : '0;
        mask_c     = mask_q | sel_c;
        complete_c = &mask_c;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            slot_c[i]            = sel_c[i] ? dec_c : slot_q[i];
            pack_data_c[i*4 +: 4] = slot_c[i].value;
            pack_blank_c[i]      = slot_c[i].blank;
            pack_err_c[i]        = slot_c[i].err;
        end
        load_c        = complete_c && (!frame_valid || frame_ack);
        overrun_set_c = complete_c && frame_valid && !frame_ack;
    end

    // Digit slots and capture mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            mask_q <= complete_c ? '0 : mask_c;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot_q[i] <= slot_c[i];
            end
        end
    end

    // Output frame register, valid/ack handshake and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data  <= '0;
            frame_blank <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (load_c) begin
                frame_data  <= pack_data_c;
                frame_blank <= pack_blank_c;
                frame_err   <= pack_err_c;
                frame_valid <= 1'b1;
            end else if (frame_ack && !complete_c) begin
                frame_valid <= 1'b0;
            end
            overrun <= overrun_set_c | (overrun & ~overrun_clr);
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture.
module tb_seg7_capture;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] frame_data;
    logic [3:0]  frame_blank;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ack;
    logic        overrun;
    logic        overrun_clr;

    int checks   = 0;
    int failures = 0;

    seg7_capture #(.STABLE_CNT(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .frame_data  (frame_data),
        .frame_blank (frame_blank),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one bus value for n rising edges.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        @(negedge clk);
        an_n  = an;
        seg_n = seg;
        repeat (n) @(posedge clk);
    endtask

    task automatic idle(input int n);
        drive(4'b1111, SEG_BLANK, n);
    endtask

    // Full scan, digit0 first, 4 edges per digit; returns just after the 16th edge.
    task automatic scan_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        drive(4'b1110, s0, 4);
        drive(4'b1101, s1, 4);
        drive(4'b1011, s2, 4);
        drive(4'b0111, s3, 4);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        an_n        = 4'b1111;
        seg_n       = SEG_BLANK;
        frame_ack   = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_valid", 32'(frame_valid), 32'h0);
        check_eq("reset_data", 32'(frame_data), 32'h0);
        check_eq("reset_flags", 32'({frame_blank, frame_err, overrun}), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Basic frame and first-frame latency.
        scan_frame(SEG_3, SEG_5, SEG_7, SEG_0);
        #1;
        check_eq("basic_not_early", 32'(frame_valid), 32'h0);
        next_edge();
        check_eq("basic_valid", 32'(frame_valid), 32'h1);
        check_eq("basic_data", 32'(frame_data), 32'h0753);
        check_eq("basic_flags", 32'({frame_blank, frame_err}), 32'h0);
        idle(2);
        ack_pulse();
        check_eq("ack_clears", 32'(frame_valid), 32'h0);

        // Debounce: glitch, short hold and double anode never commit.
        drive(4'b1110, SEG_1, 3);
        drive(4'b1110, SEG_9, 4);
        drive(4'b1101, SEG_5, 3);
        drive(4'b1100, SEG_2, 6);
        drive(4'b1011, SEG_4, 4);
        drive(4'b0111, SEG_6, 4);
        idle(3);
        check_eq("debounce_incomplete", 32'(frame_valid), 32'h0);
        drive(4'b1101, SEG_2, 4);
        next_edge();
        check_eq("debounce_valid", 32'(frame_valid), 32'h1);
        check_eq("debounce_data", 32'(frame_data), 32'h6429);
        idle(2);
        ack_pulse();

        // Blank, unrecognised and aliased patterns.
        scan_frame(SEG_8, 7'b1010101, SEG_BLANK, SEG_A);
        next_edge();
        check_eq("bea_valid", 32'(frame_valid), 32'h1);
        check_eq("bea_data", 32'(frame_data), 32'hA008);
        check_eq("bea_blank", 32'(frame_blank), 32'h4);
        check_eq("bea_err", 32'(frame_err), 32'h2);

        // Async reset mid-frame clears outputs and the capture mask.
        drive(4'b1110, SEG_1, 4);
        drive(4'b1101, SEG_2, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid", 32'(frame_valid), 32'h0);
        check_eq("rst_data", 32'(frame_data), 32'h0);
        check_eq("rst_flags", 32'({frame_blank, frame_err, overrun}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1011, SEG_3, 4);
        drive(4'b0111, SEG_4, 4);
        idle(3);
        check_eq("rst_partial", 32'(frame_valid), 32'h0);
        drive(4'b1110, SEG_5, 4);
        drive(4'b1101, SEG_6, 4);
        next_edge();
        check_eq("rst_full_valid", 32'(frame_valid), 32'h1);
        check_eq("rst_full_data", 32'(frame_data), 32'h4365);
        idle(2);
        ack_pulse();

        // Handshake and overrun.
        scan_frame(SEG_1, SEG_2, SEG_3, SEG_4);
        next_edge();
        check_eq("hs_f1_data", 32'(frame_data), 32'h4321);
        check_eq("hs_f1_overrun", 32'(overrun), 32'h0);
        scan_frame(SEG_5, SEG_6, SEG_7, SEG_8);
        next_edge();
        check_eq("hs_f2_overrun", 32'(overrun), 32'h1);
        check_eq("hs_f2_hold", 32'(frame_data), 32'h4321);
        check_eq("hs_f2_valid", 32'(frame_valid), 32'h1);
        scan_frame(SEG_9, SEG_A, SEG_B, SEG_C);
        #1;
        frame_ack = 1'b1;
        next_edge();
        frame_ack = 1'b0;
        check_eq("hs_f3_valid", 32'(frame_valid), 32'h1);
        check_eq("hs_f3_data", 32'(frame_data), 32'hCBA9);
        overrun_clr = 1'b1;
        next_edge();
        overrun_clr = 1'b0;
        check_eq("hs_clr", 32'(overrun), 32'h0);
        scan_frame(SEG_D, SEG_0, SEG_1, SEG_2);
        #1;
        overrun_clr = 1'b1;
        next_edge();
        overrun_clr = 1'b0;
        check_eq("hs_set_wins", 32'(overrun), 32'h1);
        check_eq("hs_f4_hold", 32'(frame_data), 32'hCBA9);
        idle(2);
        ack_pulse();
        check_eq("hs_final_ack", 32'(frame_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
